// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId registers, interrupt/exception request
// generation and the state updates that accompany taking one.
module cp0 (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCode_in,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] DOut,
    output logic [31:0] EPC_out,
    output logic        Req
);

    localparam logic [4:0]  REG_SR    = 5'd12;
    localparam logic [4:0]  REG_CAUSE = 5'd13;
    localparam logic [4:0]  REG_EPC   = 5'd14;
    localparam logic [4:0]  REG_PRID  = 5'd15;
    localparam logic [31:0] PRID_VAL  = 32'h2021_0007;

    // SR fields
    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    // Cause fields
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_code_q, exc_code_d;
    // EPC is word aligned, so only bits [31:2] are stored
    logic [29:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic [31:0] epc_val;

    // A faulting delay-slot instruction restarts at its branch, one word back;
    // the subtraction wraps naturally in the 30-bit word address.
    function automatic logic [29:0] epc_word(input logic [29:0] pc_word,
                                             input logic        in_delay_slot);
        return in_delay_slot ? (pc_word - 30'd1) : pc_word;
    endfunction

    assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_req = (ExcCode_in != 5'd0) & ~exl_q;
    assign Req     = int_req | exc_req;

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        cause_bd_d = cause_bd_q;
        ip_d       = HWInt;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;

        if (Req) begin
            exl_d      = 1'b1;
            exc_code_d = int_req ? 5'd0 : ExcCode_in;
            cause_bd_d = BD;
            epc_d      = epc_word(PC[31:2], BD);
        end else begin
            if (WE) begin
                case (A)
                    REG_SR: begin
                        im_d  = DIn[15:10];
                        exl_d = DIn[1];
                        ie_d  = DIn[0];
                    end
                    REG_EPC: epc_d = DIn[31:2];
                    default: ;
                endcase
            end
            // eret wins over a same-cycle mtc0 for EXL only
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            cause_bd_q <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
            epc_q      <= '0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            cause_bd_q <= cause_bd_d;
            ip_q       <= ip_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    assign sr_val    = {16'b0, im_q, 8'b0, exl_q, ie_q};
    assign cause_val = {cause_bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b00};
    assign epc_val   = {epc_q, 2'b00};
    assign EPC_out   = epc_val;

    always_comb begin
        case (A)
            REG_SR:    DOut = sr_val;
            REG_CAUSE: DOut = cause_val;
            REG_EPC:   DOut = epc_val;
            REG_PRID:  DOut = PRID_VAL;
            default:   DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// Scoreboard bench for cp0: each scenario queues the register state expected
// after its clock edge and compares it against mfc0 reads once the edge is done.
module tb_cp0;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCode_in;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] DOut;
    logic [31:0] EPC_out;
    logic        Req;

    typedef struct {
        string       tag;
        logic [31:0] sr;
        logic [31:0] cause;
        logic [31:0] epc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    cp0 dut (
        .clk(clk), .reset(reset), .A(A), .DIn(DIn), .WE(WE), .PC(PC), .BD(BD),
        .ExcCode_in(ExcCode_in), .HWInt(HWInt), .EXLClr(EXLClr),
        .DOut(DOut), .EPC_out(EPC_out), .Req(Req)
    );

    always #5 clk = ~clk;

    task automatic idle();
        reset = 1'b0; A = 5'd0; DIn = 32'd0; WE = 1'b0; PC = 32'd0; BD = 1'b0;
        ExcCode_in = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    endtask

    // One rising edge, then return the inputs to idle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic read_state(output logic [31:0] sr, output logic [31:0] cause,
                              output logic [31:0] epc, output logic [31:0] epc_o);
        A = 5'd12; #1; sr    = DOut;
        A = 5'd13; #1; cause = DOut;
        A = 5'd14; #1; epc   = DOut; epc_o = EPC_out;
        A = 5'd0;
    endtask

    task automatic push(input string tag, input logic [31:0] sr,
                        input logic [31:0] cause, input logic [31:0] epc);
        exp_t e;
        e.tag = tag; e.sr = sr; e.cause = cause; e.epc = epc;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] sr, cause, epc, epco;
        idle();
        reset = 1'b1; WE = 1'b1; A = 5'd12; DIn = 32'hFFFF_FFFF; ExcCode_in = 5'd12;
        push("reset", 32'h0, 32'h0, 32'h0);
        step();
        e = sb.pop_front();
        read_state(sr, cause, epc, epco);
        n_checks++; if (sr !== e.sr) begin n_fail++; $display("FAIL %s SR got %h want %h", e.tag, sr, e.sr); end
        n_checks++; if (cause !== e.cause) begin n_fail++; $display("FAIL %s Cause got %h want %h", e.tag, cause, e.cause); end
        n_checks++; if (epc !== e.epc) begin n_fail++; $display("FAIL %s EPC got %h want %h", e.tag, epc, e.epc); end
        HWInt = 6'h3F; A = 5'd3; #1;
        n_checks++; if (Req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", Req); end
        n_checks++; if (DOut !== 32'd0) begin n_fail++; $display("FAIL unmapped_read got %h want 0", DOut); end
        idle();
    endtask

    task automatic test_interrupt();
        exp_t e;
        logic [31:0] sr, cause, epc, epco;
        WE = 1'b1; A = 5'd12; DIn = 32'h0000_FC01;
        push("mtc0_sr", 32'h0000_FC01, 32'h0, 32'h0);
        step();
        e = sb.pop_front();
        read_state(sr, cause, epc, epco);
        n_checks++; if (sr !== e.sr) begin n_fail++; $display("FAIL %s SR got %h want %h", e.tag, sr, e.sr); end

        HWInt = 6'b000100; PC = 32'h0000_3010; BD = 1'b0; #1;
        n_checks++; if (Req !== 1'b1) begin n_fail++; $display("FAIL int_req got %b want 1", Req); end
        push("interrupt", 32'h0000_FC03, 32'h0000_1000, 32'h0000_3010);
        step();
        e = sb.pop_front();
        read_state(sr, cause, epc, epco);
        n_checks++; if (sr !== e.sr) begin n_fail++; $display("FAIL %s SR got %h want %h", e.tag, sr, e.sr); end
        n_checks++; if (cause !== e.cause) begin n_fail++; $display("FAIL %s Cause got %h want %h", e.tag, cause, e.cause); end
        n_checks++; if (epc !== e.epc) begin n_fail++; $display("FAIL %s EPC got %h want %h", e.tag, epc, e.epc); end
        n_checks++; if (epco !== e.epc) begin n_fail++; $display("FAIL %s EPC_out got %h want %h", e.tag, epco, e.epc); end

        EXLClr = 1'b1;
        push("eret", 32'h0000_FC01, 32'h0, 32'h0000_3010);
        step();
        e = sb.pop_front();
        read_state(sr, cause, epc, epco);
        n_checks++; if (sr !== e.sr) begin n_fail++; $display("FAIL %s SR got %h want %h", e.tag, sr, e.sr); end
        n_checks++; if (cause !== e.cause) begin n_fail++; $display("FAIL %s Cause got %h want %h", e.tag, cause, e.cause); end
    endtask

    task automatic test_exception_bd();
        exp_t e;
        logic [31:0] sr, cause, epc, epco;
        ExcCode_in = 5'd12; PC = 32'h0000_3024; BD = 1'b1; #1;
        n_checks++; if (Req !== 1'b1) begin n_fail++; $display("FAIL exc_req got %b want 1", Req); end
        push("exc_bd", 32'h0000_FC03, 32'h8000_0030, 32'h0000_3020);
        step();
        e = sb.pop_front();
        read_state(sr, cause, epc, epco);
        n_checks++; if (sr !== e.sr) begin n_fail++; $display("FAIL %s SR got %h want %h", e.tag, sr, e.sr); end
        n_checks++; if (cause !== e.cause) begin n_fail++; $display("FAIL %s Cause got %h want %h", e.tag, cause, e.cause); end
        n_checks++; if (epc !== e.epc) begin n_fail++; $display("FAIL %s EPC got %h want %h", e.tag, epc, e.epc); end
    endtask

    task automatic test_exl_block();
        exp_t e;
        logic [31:0] sr, cause, epc, epco;
        // EXL still set: nothing is taken; only Cause.IP keeps tracking HWInt.
        ExcCode_in = 5'd10; HWInt = 6'b000100; PC = 32'h0000_5000; #1;
        n_checks++; if (Req !== 1'b0) begin n_fail++; $display("FAIL exl_block_req got %b want 0", Req); end
        push("exl_block", 32'h0000_FC03, 32'h8000_1030, 32'h0000_3020);
        step();
        e = sb.pop_front();
        read_state(sr, cause, epc, epco);
        n_checks++; if (sr !== e.sr) begin n_fail++; $display("FAIL %s SR got %h want %h", e.tag, sr, e.sr); end
        n_checks++; if (cause !== e.cause) begin n_fail++; $display("FAIL %s Cause got %h want %h", e.tag, cause, e.cause); end
        n_checks++; if (epc !== e.epc) begin n_fail++; $display("FAIL %s EPC got %h want %h", e.tag, epc, e.epc); end
    endtask

    task automatic test_eret_mtc0();
        exp_t e;
        logic [31:0] sr, cause, epc, epco;
        EXLClr = 1'b1; WE = 1'b1; A = 5'd12; DIn = 32'h0000_0403;
        push("eret_mtc0", 32'h0000_0401, 32'h8000_0030, 32'h0000_3020);
        step();
        e = sb.pop_front();
        read_state(sr, cause, epc, epco);
        n_checks++; if (sr !== e.sr) begin n_fail++; $display("FAIL %s SR got %h want %h", e.tag, sr, e.sr); end
        n_checks++; if (cause !== e.cause) begin n_fail++; $display("FAIL %s Cause got %h want %h", e.tag, cause, e.cause); end
        A = 5'd15; #1;
        n_checks++; if (DOut !== 32'h2021_0007) begin n_fail++; $display("FAIL prid got %h want 20210007", DOut); end
        A = 5'd0;
    endtask

    task automatic test_write_ignore();
        exp_t e;
        logic [31:0] sr, cause, epc, epco;
        WE = 1'b1; A = 5'd13; DIn = 32'hFFFF_FFFF;
        step();
        WE = 1'b1; A = 5'd15; DIn = 32'hFFFF_FFFF;
        step();
        WE = 1'b1; A = 5'd14; DIn = 32'h1234_5677;
        push("epc_write", 32'h0000_0401, 32'h8000_0030, 32'h1234_5674);
        step();
        e = sb.pop_front();
        read_state(sr, cause, epc, epco);
        n_checks++; if (cause !== e.cause) begin n_fail++; $display("FAIL %s Cause got %h want %h", e.tag, cause, e.cause); end
        n_checks++; if (epc !== e.epc) begin n_fail++; $display("FAIL %s EPC got %h want %h", e.tag, epc, e.epc); end
        n_checks++; if (epco !== e.epc) begin n_fail++; $display("FAIL %s EPC_out got %h want %h", e.tag, epco, e.epc); end
        A = 5'd15; #1;
        n_checks++; if (DOut !== 32'h2021_0007) begin n_fail++; $display("FAIL prid_ro got %h want 20210007", DOut); end
    endtask

    task automatic test_priority();
        exp_t e;
        logic [31:0] sr, cause, epc, epco;
        HWInt = 6'b000001; ExcCode_in = 5'd4; PC = 32'h0000_3030; BD = 1'b0;
        WE = 1'b1; A = 5'd14; DIn = 32'h0000_1234; #1;
        n_checks++; if (Req !== 1'b1) begin n_fail++; $display("FAIL prio_req got %b want 1", Req); end
        push("priority", 32'h0000_0403, 32'h0000_0400, 32'h0000_3030);
        step();
        e = sb.pop_front();
        read_state(sr, cause, epc, epco);
        n_checks++; if (sr !== e.sr) begin n_fail++; $display("FAIL %s SR got %h want %h", e.tag, sr, e.sr); end
        n_checks++; if (cause !== e.cause) begin n_fail++; $display("FAIL %s Cause got %h want %h", e.tag, cause, e.cause); end
        n_checks++; if (epc !== e.epc) begin n_fail++; $display("FAIL %s EPC got %h want %h", e.tag, epc, e.epc); end
    endtask

    task automatic test_reset_exl();
        exp_t e;
        logic [31:0] sr, cause, epc, epco;
        WE = 1'b1; A = 5'd14; DIn = 32'h0000_3040;
        step();
        read_state(sr, cause, epc, epco);
        n_checks++; if (epc !== 32'h0000_3040) begin n_fail++; $display("FAIL pre_reset_epc got %h want 00003040", epc); end
        reset = 1'b1; EXLClr = 1'b0; HWInt = 6'h3F; ExcCode_in = 5'd12;
        push("reset_exl", 32'h0, 32'h0, 32'h0);
        step();
        e = sb.pop_front();
        read_state(sr, cause, epc, epco);
        n_checks++; if (sr !== e.sr) begin n_fail++; $display("FAIL %s SR got %h want %h", e.tag, sr, e.sr); end
        n_checks++; if (cause !== e.cause) begin n_fail++; $display("FAIL %s Cause got %h want %h", e.tag, cause, e.cause); end
        n_checks++; if (epc !== e.epc) begin n_fail++; $display("FAIL %s EPC got %h want %h", e.tag, epc, e.epc); end
        HWInt = 6'h3F; #1;
        n_checks++; if (Req !== 1'b0) begin n_fail++; $display("FAIL reset_exl_req got %b want 0", Req); end
        idle();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] sr, cause, epc, epco;
        // Delay-slot exception at PC 0 wraps EPC; the next cycle is blocked by EXL.
        ExcCode_in = 5'd5; PC = 32'h0000_0002; BD = 1'b1; #1;
        n_checks++; if (Req !== 1'b1) begin n_fail++; $display("FAIL wrap_req got %b want 1", Req); end
        push("wrap", 32'h0000_0002, 32'h8000_0014, 32'hFFFF_FFFC);
        step();
        ExcCode_in = 5'd4; PC = 32'h0000_7000; BD = 1'b0; #1;
        n_checks++; if (Req !== 1'b0) begin n_fail++; $display("FAIL b2b_req got %b want 0", Req); end
        step();
        e = sb.pop_front();
        read_state(sr, cause, epc, epco);
        n_checks++; if (sr !== e.sr) begin n_fail++; $display("FAIL %s SR got %h want %h", e.tag, sr, e.sr); end
        n_checks++; if (cause !== e.cause) begin n_fail++; $display("FAIL %s Cause got %h want %h", e.tag, cause, e.cause); end
        n_checks++; if (epc !== e.epc) begin n_fail++; $display("FAIL %s EPC got %h want %h", e.tag, epc, e.epc); end
    endtask

    initial begin
        idle();
        @(negedge clk);
        test_reset();
        test_interrupt();
        test_exception_bd();
        test_exl_block();
        test_eret_mtc0();
        test_write_ignore();
        test_priority();
        test_reset_exl();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
